vga_label_engine: RTL and testbench

VGA_LABEL_ENGINE -- requirements
Module: vga_label_engine

---
 rtl/vga_label_engine_if.sv | 31 +++
 rtl/vga_label_engine.sv | 158 +++++++++++++++
 tb/tb_vga_label_engine.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_label_engine_if.sv
// vga_label_engine_if: label-table configuration bus for vga_label_engine
// Signals:
//   cfg_we                  write strobe; one entry is updated per strobe
//   cfg_idx                 target entry (IDX_W bits); out-of-range indices are dropped by the engine
//   cfg_line / cfg_col      label origin in cells
//   cfg_width               label length in characters (0 = empty)
//   cfg_offset              base address of the label text in the character RAM
//   cfg_color / cfg_zoom    foreground colour and zoom exponent
//   cfg_en / cfg_blink      channel enable and blink request
// Modports: master drives the bus, slave (the engine) samples it.
interface vga_label_engine_if #(
    parameter int NLABELS = 4,
    parameter int ADDR_W  = 8,
    parameter int ZOOM_W  = 2
);
    localparam int IDX_W = NLABELS > 1 ? $clog2(NLABELS) : 1;
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [6:0]        cfg_line;
    logic [6:0]        cfg_col;
    logic [7:0]        cfg_width;
    logic [ADDR_W-1:0] cfg_offset;
    logic [2:0]        cfg_color;
    logic [ZOOM_W-1:0] cfg_zoom;
    logic              cfg_en;
    logic              cfg_blink;
    modport master (output cfg_we, cfg_idx, cfg_line, cfg_col, cfg_width, cfg_offset,
                    cfg_color, cfg_zoom, cfg_en, cfg_blink);
    modport slave  (input  cfg_we, cfg_idx, cfg_line, cfg_col, cfg_width, cfg_offset,
                    cfg_color, cfg_zoom, cfg_en, cfg_blink);
endinterface

// File: rtl/vga_label_engine.sv
// vga_label_engine: four-stage text-label overlay on a VGA pixel stream
// Optional feature: define VGA_LABEL_BLINK_EN for per-label blinking driven by frame_cnt[5].
// Ports:
//   px_clk, reset              pixel clock, synchronous active-high reset
//   hsync_in, vsync_in, av_in  sync and active-video from the timing generator
//   x_in, y_in                 current pixel position
//   cfg                        label-table write bus (vga_label_engine_if.slave)
//   ram_addr, ram_data         character RAM; data is sampled on the edge after the address
//   font_char/row/col,font_bit glyph lookup; the bit is sampled on the edge after the lookup
//   rgb, hsync, vsync          pixel colour and sync, four cycles behind the inputs
//   frame_cnt                  completed frames, wraps 255 -> 0
module vga_label_engine #(
    parameter int         NLABELS = 4,
    parameter int         ADDR_W  = 8,
    parameter int         ZOOM_W  = 2,
    parameter logic [2:0] DEF_BG  = 3'b000
) (
    input  logic              px_clk,
    input  logic              reset,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              av_in,
    input  logic [9:0]        x_in,
    input  logic [9:0]        y_in,
    vga_label_engine_if.slave cfg,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_data,
    output logic [7:0]        font_char,
    output logic [2:0]        font_row,
    output logic [2:0]        font_col,
    input  logic              font_bit,
    output logic [2:0]        rgb,
    output logic              hsync,
    output logic              vsync,
    output logic [7:0]        frame_cnt
);
    localparam int IDX_W = NLABELS > 1 ? $clog2(NLABELS) : 1;

    logic [6:0]        t_line  [NLABELS];
    logic [6:0]        t_col   [NLABELS];
    logic [7:0]        t_width [NLABELS];
    logic [ADDR_W-1:0] t_off   [NLABELS];
    logic [2:0]        t_color [NLABELS];
    logic [ZOOM_W-1:0] t_zoom  [NLABELS];
    logic [NLABELS-1:0] t_en;

    logic [8:0]        cx [NLABELS];
    logic              hit, wr, blank;
    logic [IDX_W-1:0]  sel;
    logic [ADDR_W-1:0] addr, s0_addr;
    logic [2:0]        row, col, s0_row, s0_col, s1_row, s1_col;
    logic [2:0]        s0_color, s1_color, s2_color;
    logic              s0_hit, s1_hit, s2_hit, s0_eof;
    logic [2:0]        hs_p, vs_p;

    assign wr = cfg.cfg_we && 32'(cfg.cfg_idx) < NLABELS;

    // Descending scan so the lowest-index hit is the one left in sel.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int k = NLABELS - 1; k >= 0; k--) begin
            cx[k] = 9'(x_in >> (32'(t_zoom[k]) + 3));
            if (av_in && t_en[k] && (y_in >> (32'(t_zoom[k]) + 3)) == {3'b000, t_line[k]}
                && {2'b00, t_col[k]} <= cx[k] && cx[k] < {2'b00, t_col[k]} + {1'b0, t_width[k]}) begin
                hit = 1'b1;
                sel = IDX_W'(k);
            end
        end
    end

    assign addr = t_off[sel] + ADDR_W'(cx[sel] - {2'b00, t_col[sel]});
    assign row  = 3'(y_in >> t_zoom[sel]);
    assign col  = 3'(x_in >> t_zoom[sel]);

    always_ff @(posedge px_clk) begin
        if (reset) begin
            t_en <= '0;
            for (int k = 0; k < NLABELS; k++) begin
                t_line[k]  <= '0;
                t_col[k]   <= '0;
                t_width[k] <= '0;
                t_off[k]   <= '0;
                t_color[k] <= '0;
                t_zoom[k]  <= '0;
            end
        end else if (wr) begin
            t_en[cfg.cfg_idx]    <= cfg.cfg_en;
            t_line[cfg.cfg_idx]  <= cfg.cfg_line;
            t_col[cfg.cfg_idx]   <= cfg.cfg_col;
            t_width[cfg.cfg_idx] <= cfg.cfg_width;
            t_off[cfg.cfg_idx]   <= cfg.cfg_offset;
            t_color[cfg.cfg_idx] <= cfg.cfg_color;
            t_zoom[cfg.cfg_idx]  <= cfg.cfg_zoom;
        end
    end

    // Everything a pixel needs is captured in S0, so later table writes cannot touch it.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            {s0_hit, s1_hit, s2_hit, s0_eof} <= '0;
            {s0_addr, ram_addr, font_char} <= '0;
            {s0_row, s0_col, s1_row, s1_col, font_row, font_col} <= '0;
            {s0_color, s1_color, s2_color} <= '0;
            hs_p      <= '1;
            vs_p      <= '1;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            rgb       <= DEF_BG;
            frame_cnt <= '0;
        end else begin
            s0_hit    <= hit;
            s0_eof    <= x_in == 10'd639 && y_in == 10'd479;
            s0_addr   <= addr;
            s0_row    <= row;
            s0_col    <= col;
            s0_color  <= t_color[sel];
            hs_p      <= {hs_p[1:0], hsync_in};
            vs_p      <= {vs_p[1:0], vsync_in};
            s1_hit    <= s0_hit;
            ram_addr  <= s0_addr;
            s1_row    <= s0_row;
            s1_col    <= s0_col;
            s1_color  <= s0_color;
            s2_hit    <= s1_hit;
            font_char <= ram_data;
            font_row  <= s1_row;
            font_col  <= s1_col;
            s2_color  <= s1_color;
            rgb       <= s2_hit && font_bit && !blank ? s2_color : DEF_BG;
            hsync     <= hs_p[2];
            vsync     <= vs_p[2];
            frame_cnt <= frame_cnt + 8'(s0_eof);
        end
    end

`ifdef VGA_LABEL_BLINK_EN
    logic [NLABELS-1:0] t_blink;
    logic               s0_blink, s1_blink, s2_blink;

    always_ff @(posedge px_clk) begin
        if (reset) begin
            t_blink <= '0;
            {s0_blink, s1_blink, s2_blink} <= '0;
        end else begin
            if (wr)
                t_blink[cfg.cfg_idx] <= cfg.cfg_blink;
            s0_blink <= hit && t_blink[sel];
            s1_blink <= s0_blink;
            s2_blink <= s1_blink;
        end
    end

    assign blank = s2_blink && frame_cnt[5];
`else
    assign blank = 1'b0;
`endif
endmodule

// File: tb/tb_vga_label_engine.sv
// tb_vga_label_engine: scoreboard bench for vga_label_engine (3 channels, 8-bit RAM address)
module tb_vga_label_engine;
    localparam int NL = 3;
`ifdef VGA_LABEL_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    typedef struct { int due; logic [2:0] rgb; logic hs; logic vs; } out_t;
    typedef struct { int due; logic [7:0] addr; } adr_t;
    typedef struct { int due; logic [7:0] ch; logic [2:0] row; logic [2:0] col; } fnt_t;

    logic       px_clk = 1'b0, reset = 1'b1;
    logic       hsync_in = 1'b1, vsync_in = 1'b1, av_in = 1'b0;
    logic [9:0] x_in = '0, y_in = '0;
    logic [7:0] ram_addr, ram_data, font_char, frame_cnt;
    logic [2:0] font_row, font_col, rgb;
    logic       font_bit, hsync, vsync;
    logic [7:0] mem [256];

    int   cyc = 0, n_chk = 0, n_fail = 0;
    out_t q_out[$];
    adr_t q_adr[$];
    fnt_t q_fnt[$];
    out_t mo;
    adr_t ma;
    fnt_t mf;

    int       m_en[4], m_line[4], m_col[4], m_w[4], m_off[4], m_color[4], m_zoom[4], m_blink[4];
    logic [7:0] m_fc = '0;

    vga_label_engine_if #(.NLABELS(NL), .ADDR_W(8), .ZOOM_W(2)) cfg_bus ();

    vga_label_engine #(.NLABELS(NL), .ADDR_W(8), .ZOOM_W(2), .DEF_BG(3'b000)) dut (
        .px_clk(px_clk), .reset(reset),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .av_in(av_in),
        .x_in(x_in), .y_in(y_in), .cfg(cfg_bus),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .font_char(font_char), .font_row(font_row), .font_col(font_col), .font_bit(font_bit),
        .rgb(rgb), .hsync(hsync), .vsync(vsync), .frame_cnt(frame_cnt)
    );

    always #5 px_clk = ~px_clk;
    always @(posedge px_clk) cyc <= cyc + 1;

    // Character RAM and glyph ROM models, both answering within the cycle.
    assign ram_data = mem[ram_addr];
    assign font_bit = font_char[font_col] ^ font_row[0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge px_clk) begin
        while (q_out.size() > 0 && q_out[0].due <= cyc) begin
            mo = q_out.pop_front();
            chk("rgb", 32'(rgb), 32'(mo.rgb));
            chk("hsync", 32'(hsync), 32'(mo.hs));
            chk("vsync", 32'(vsync), 32'(mo.vs));
        end
        while (q_adr.size() > 0 && q_adr[0].due <= cyc) begin
            ma = q_adr.pop_front();
            chk("ram_addr", 32'(ram_addr), 32'(ma.addr));
        end
        while (q_fnt.size() > 0 && q_fnt[0].due <= cyc) begin
            mf = q_fnt.pop_front();
            chk("font_char", 32'(font_char), 32'(mf.ch));
            chk("font_row", 32'(font_row), 32'(mf.row));
            chk("font_col", 32'(font_col), 32'(mf.col));
        end
    end

    // Drive one pixel, predict its results from the bench's own label table, advance a cycle.
    task automatic step(input int x, input int y, input bit av, input bit hs, input bit vs, input bit probe);
        int   sel, z, a, r, c;
        bit   fb, bl;
        out_t o;
        adr_t pa;
        fnt_t pf;
        x_in = 10'(x); y_in = 10'(y); av_in = av; hsync_in = hs; vsync_in = vs;
        sel = -1;
        for (int k = NL - 1; k >= 0; k--) begin
            z = m_zoom[k];
            if (av && m_en[k] != 0 && (y >> (3 + z)) == m_line[k] && (x >> (3 + z)) >= m_col[k]
                && (x >> (3 + z)) < m_col[k] + m_w[k])
                sel = k;
        end
        o.due = cyc + 4; o.rgb = 3'b000; o.hs = hs; o.vs = vs;
        if (sel >= 0) begin
            z = m_zoom[sel];
            a = (m_off[sel] + (x >> (3 + z)) - m_col[sel]) & 255;
            r = (y >> z) & 7;
            c = (x >> z) & 7;
            fb = mem[a][c] ^ r[0];
            bl = BLINK_ON && m_blink[sel] != 0 && m_fc[5];
            if (fb && !bl) o.rgb = 3'(m_color[sel]);
            if (probe && !reset) begin
                pa.due = cyc + 2; pa.addr = 8'(a);
                pf.due = cyc + 3; pf.ch = mem[a]; pf.row = 3'(r); pf.col = 3'(c);
                q_adr.push_back(pa);
                q_fnt.push_back(pf);
            end
        end
        if (reset) begin
            o.rgb = 3'b000; o.hs = 1'b1; o.vs = 1'b1;
        end
        q_out.push_back(o);
        if (x == 639 && y == 479 && !reset) m_fc++;
        @(posedge px_clk);
        #1;
        cfg_bus.cfg_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 1, 0);
    endtask

    task automatic bump(input int n);
        for (int i = 0; i < n; i++) step(639, 479, 0, 1, 1, 0);
        idle(4);
    endtask

    task automatic wr(input int idx, input int line, input int col, input int w, input int off,
                      input int color, input int zoom, input int en, input int blink);
        cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_idx = 2'(idx);
        cfg_bus.cfg_line = 7'(line); cfg_bus.cfg_col = 7'(col); cfg_bus.cfg_width = 8'(w);
        cfg_bus.cfg_offset = 8'(off); cfg_bus.cfg_color = 3'(color); cfg_bus.cfg_zoom = 2'(zoom);
        cfg_bus.cfg_en = 1'(en); cfg_bus.cfg_blink = 1'(blink);
        step(0, 0, 0, 1, 1, 0);
        if (!reset && idx < NL) begin
            m_en[idx] = en; m_line[idx] = line; m_col[idx] = col; m_w[idx] = w;
            m_off[idx] = off; m_color[idx] = color; m_zoom[idx] = zoom; m_blink[idx] = blink;
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            m_en[k] = 0; m_line[k] = 0; m_col[k] = 0; m_w[k] = 0;
            m_off[k] = 0; m_color[k] = 0; m_zoom[k] = 0; m_blink[k] = 0;
        end
        m_fc = '0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 5);
        clear_model();
        cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_idx = '0; cfg_bus.cfg_line = '0; cfg_bus.cfg_col = '0;
        cfg_bus.cfg_width = '0; cfg_bus.cfg_offset = '0; cfg_bus.cfg_color = '0;
        cfg_bus.cfg_zoom = '0; cfg_bus.cfg_en = 1'b0; cfg_bus.cfg_blink = 1'b0;
        @(posedge px_clk);
        #1;

        // Reset state; a write issued during reset must be dropped.
        wr(0, 10, 20, 8, 60, 5, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(160 + i, 80, 1, 0, 0, 0);
        chk("rst_rgb", 32'(rgb), 0);
        chk("rst_hsync", 32'(hsync), 1);
        chk("rst_vsync", 32'(vsync), 1);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_font_char", 32'(font_char), 0);
        chk("rst_font_row", 32'(font_row), 0);
        chk("rst_font_col", 32'(font_col), 0);
        reset = 1'b0;
        for (int x = 160; x < 168; x++) step(x, 80, 1, 1, 1, 1);

        // Single label, overlapping pair, and a wrapping label with blink requested.
        wr(0, 10, 20, 8, 60, 5, 0, 1, 0);
        wr(1, 5, 5, 1, 200, 3, 0, 1, 0);
        wr(2, 20, 0, 10, 250, 6, 0, 1, 1);
        for (int y = 80; y < 88; y += 7)
            for (int x = 150; x < 232; x++)
                step(x, y, 1, (x >= 224 && x < 228) ? 1'b0 : 1'b1, y == 87 ? 1'b0 : 1'b1, 1);

        // Rewrite channel 0 while line-87 pixels are still in flight.
        wr(0, 2, 2, 4, 100, 4, 1, 1, 0);
        for (int x = 30; x < 70; x++) step(x, 40, 1, 1, 1, 1);
        wr(0, 2, 2, 4, 100, 4, 1, 0, 0);
        for (int x = 36; x < 50; x++) step(x, 41, 1, 1, 1, 1);

        // Address wrap, right edge, and an out-of-range index.
        for (int x = 0; x < 90; x++) step(x, 160, 1, 1, 1, 1);
        wr(3, 20, 0, 16, 0, 7, 0, 1, 0);
        for (int x = 78; x < 100; x++) step(x, 160, 1, 1, 1, 1);

        // Frame counter and blink window.
        bump(31);
        chk("frame_cnt_31", 32'(frame_cnt), 32'(m_fc));
        for (int x = 0; x < 16; x++) step(x, 161, 1, 1, 1, 1);
        idle(4);
        bump(1);
        chk("frame_cnt_32", 32'(frame_cnt), 32'(m_fc));
        for (int x = 0; x < 16; x++) step(x, 161, 1, 1, 1, 1);
        idle(4);
        bump(224);
        chk("frame_cnt_wrap", 32'(frame_cnt), 0);
        bump(3);
        chk("frame_cnt_3", 32'(frame_cnt), 32'(m_fc));

        // Reset in the middle of a label line.
        for (int x = 0; x < 20; x++) step(x, 160, 1, 1, 1, 1);
        foreach (q_out[i]) if (q_out[i].due > cyc) begin
            q_out[i].rgb = 3'b000; q_out[i].hs = 1'b1; q_out[i].vs = 1'b1;
        end
        while (q_adr.size() > 0 && q_adr[$].due > cyc) void'(q_adr.pop_back());
        while (q_fnt.size() > 0 && q_fnt[$].due > cyc) void'(q_fnt.pop_back());
        reset = 1'b1;
        clear_model();
        step(20, 160, 1, 0, 0, 0);
        chk("midrst_rgb", 32'(rgb), 0);
        chk("midrst_hsync", 32'(hsync), 1);
        chk("midrst_frame_cnt", 32'(frame_cnt), 0);
        reset = 1'b0;
        for (int x = 0; x < 24; x++) step(x, 160, 1, 1, 1, 1);

        for (int i = 0; i < 10 && (q_out.size() + q_adr.size() + q_fnt.size()) > 0; i++) @(posedge px_clk);
        #1;
        chk("drain", 32'(q_out.size() + q_adr.size() + q_fnt.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
